// File: rtl/jelly_integer_stream_accumulator.sv
// Integer stream accumulator built from carry-save unit adders.
// Partial carries ripple one unit per cycle; a flush drains them before output.
module jelly_integer_stream_accumulator #(
  parameter int SIGNED = 0,
  parameter int ACCUMULATOR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int UNIT_WIDTH = 32,
  parameter int COUNT_WIDTH = 16,
  parameter logic [ACCUMULATOR_WIDTH-1:0] INIT_VALUE = 'x
) (
  input  logic                         reset,
  input  logic                         clk,
  input  logic                         cke,
  input  logic                         s_first,
  input  logic                         s_last,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [ACCUMULATOR_WIDTH-1:0] m_accumulator,
  output logic [COUNT_WIDTH-1:0]       m_count,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy
);

  localparam int UNIT_NUM =
    (ACCUMULATOR_WIDTH + UNIT_WIDTH - 1) / UNIT_WIDTH;
  localparam int TOTAL_WIDTH = UNIT_NUM * UNIT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_FLUSH,
    ST_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic [TOTAL_WIDTH-1:0]   unit_q, unit_d;
  logic [UNIT_NUM-1:0]      carry_q, carry_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     m_valid_q, m_valid_d;

  logic                     accept;
  logic [TOTAL_WIDTH-1:0]   ext_data;
  logic [TOTAL_WIDTH-1:0]   add_data;
  logic [TOTAL_WIDTH-1:0]   add_unit;
  logic [UNIT_NUM-1:0]      add_carry;
  logic [UNIT_NUM-1:0]      cin;
  logic [UNIT_WIDTH:0]      seg_sum;

  assign s_ready = (state_q == ST_IDLE) || (state_q == ST_ACC);
  assign accept  = cke & s_valid & s_ready;
  assign busy    = |carry_q;

  assign m_accumulator = unit_q[ACCUMULATOR_WIDTH-1:0];
  assign m_count       = count_q;
  assign m_valid       = m_valid_q;

  // Widen the sample to the full unit span
  always_comb begin
    ext_data = '0;
    if (SIGNED != 0) begin
      ext_data = TOTAL_WIDTH'($signed(s_data));
    end else begin
      ext_data = TOTAL_WIDTH'(s_data);
    end
  end

  // One segment add per unit using last cycle's carries; top carry dropped
  always_comb begin
    add_unit  = '0;
    add_carry = '0;
    seg_sum   = '0;
    add_data  = accept ? ext_data : '0;
    cin       = carry_q << 1;
    for (int i = 0; i < UNIT_NUM; i++) begin
      seg_sum = {1'b0, unit_q[i*UNIT_WIDTH +: UNIT_WIDTH]}
              + {1'b0, add_data[i*UNIT_WIDTH +: UNIT_WIDTH]}
              + (UNIT_WIDTH+1)'(cin[i]);
      add_unit[i*UNIT_WIDTH +: UNIT_WIDTH] = seg_sum[UNIT_WIDTH-1:0];
      add_carry[i] = (i < UNIT_NUM - 1) ? seg_sum[UNIT_WIDTH] : 1'b0;
    end
  end

  // Next-state: load, accumulate, drain carries, then hold result
  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    carry_d   = carry_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;
    if (cke) begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            unit_d  = ext_data;
            carry_d = '0;
            count_d = COUNT_WIDTH'(1);
            state_d = s_last ? ST_FLUSH : ST_ACC;
          end
        end
        ST_ACC: begin
          if (accept && s_first) begin
            unit_d  = ext_data;
            carry_d = '0;
            count_d = COUNT_WIDTH'(1);
          end else begin
            unit_d  = add_unit;
            carry_d = add_carry;
            if (accept) begin
              count_d = count_q + 1'b1;
            end
          end
          if (accept && s_last) begin
            state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          unit_d  = add_unit;
          carry_d = add_carry;
          if (!busy) begin
            state_d   = ST_OUT;
            m_valid_d = 1'b1;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      unit_q    <= TOTAL_WIDTH'(INIT_VALUE);
      carry_q   <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: doc/jelly_integer_stream_accumulator.md
JELLY_INTEGER_STREAM_ACCUMULATOR -- requirements
Module: jelly_integer_stream_accumulator

Interface
REQ-001 SHALL have parameter SIGNED, default 0: 1 = sign-extend s_data, 0 = zero-extend.
REQ-002 SHALL have parameter ACCUMULATOR_WIDTH, default 64: result width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: input sample width, at most ACCUMULATOR_WIDTH.
REQ-004 SHALL have parameter UNIT_WIDTH, default 32: adder segment width; UNIT_NUM = ceil(ACCUMULATOR_WIDTH/UNIT_WIDTH).
REQ-005 SHALL have parameter COUNT_WIDTH, default 16: sample counter width.
REQ-006 SHALL have parameter INIT_VALUE, default all-x, ACCUMULATOR_WIDTH bits: accumulator reset value.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-009 SHALL have port cke, input, 1 bit: clock enable; when 0, all state and outputs freeze.
REQ-010 SHALL have ports s_first, s_last, s_valid (inputs, 1 bit) and s_data (input, DATA_WIDTH bits): input sample stream.
REQ-011 SHALL have port s_ready, output, 1 bit: input accept.
REQ-012 SHALL have ports m_accumulator (output, ACCUMULATOR_WIDTH bits), m_count (output, COUNT_WIDTH bits), m_valid (output, 1 bit) and m_ready (input, 1 bit): result stream.
REQ-013 SHALL have port busy, output, 1 bit: OR of inter-unit carries 0..UNIT_NUM-2.

Function
REQ-014 Accept condition SHALL be cke & s_valid & s_ready.
REQ-015 FSM SHALL have states IDLE, ACC, FLUSH, OUT; s_ready SHALL be 1 in IDLE/ACC and 0 in FLUSH/OUT (combinational from state).
REQ-016 Extended data SHALL be s_data sign- or zero-extended (per SIGNED) to UNIT_NUM*UNIT_WIDTH bits.
REQ-017 Accepted beat in IDLE, or with s_first=1 in ACC, SHALL load extended data into all units, clear all carries, set count=1.
REQ-018 Other accepted beats in ACC SHALL, per unit i, add unit i + data segment i + carry[i-1] (carry[-1]=0), register sum and carry-out, count+1 modulo 2^COUNT_WIDTH.
REQ-019 Cycles in ACC/FLUSH with no accepted beat (cke=1) SHALL perform the REQ-018 add with zero data and leave count unchanged.
REQ-020 Carry out of unit UNIT_NUM-1 SHALL be discarded; result is modulo 2^ACCUMULATOR_WIDTH.
REQ-021 IDLE->ACC on accepted beat with s_last=0; IDLE/ACC->FLUSH on accepted beat with s_last=1 (s_first&s_last = single-sample result).
REQ-022 In FLUSH: busy=1 -> stay and propagate; busy=0 -> go to OUT and set m_valid=1 on the same edge.
REQ-023 m_valid SHALL rise 2+k cycles after the s_last accept edge, k = FLUSH cycles with busy=1 (k <= UNIT_NUM-1; k=0 when UNIT_NUM=1).
REQ-024 In OUT, m_accumulator/m_count SHALL be stable and m_valid held until cke & m_ready; then m_valid=0, state IDLE.
REQ-025 m_accumulator SHALL equal the low ACCUMULATOR_WIDTH bits of the unit registers at all times; m_count equals the counter.

Reset
REQ-026 Reset SHALL win over cke and force: state IDLE, carries 0, units = INIT_VALUE, count 0, m_valid 0, busy 0.
REQ-027 Reset asserted in any state, including FLUSH/OUT, SHALL abort the operation with no output beat.

Verification (ACC=64, UNIT=32, DATA=32, COUNT=16 unless stated)
REQ-028 Unsigned: 0xFFFFFFFF (first), 0x1 (last), m_ready=1 -> m_accumulator 0x0000_0001_0000_0000, m_count 2, m_valid 3 cycles after last accept, one-cycle busy.
REQ-029 SIGNED=1: 0xFFFFFFFF (first), 0x2 (last) -> m_accumulator 0x1, m_count 2.
REQ-030 UNIT=64, 0x5 (first & last) -> m_accumulator 0x5, m_count 1, m_valid 2 cycles after accept; s_ready 0 until handshake.
REQ-031 m_ready low 5 cycles in OUT -> m_valid and data stable, s_ready 0; m_ready=1 -> IDLE next cycle, s_ready 1.
REQ-032 cke low 3 cycles during FLUSH -> no state change; reset in FLUSH -> m_valid never rises, m_accumulator INIT_VALUE.
